// File: rtl/tetromino_fetch_if.sv
// tetromino_fetch_if
//   Bundles the request handshake, the BRAM port-0 read bus and the result
//   handshake of tetromino_fetch.
//   master : the fetch block (drives o_*, samples i_*)
//   slave  : the surrounding logic / BRAM (drives i_*, samples o_*)
//   Request : i_req_valid, o_req_ready, i_req_id[2:0], i_req_rot[1:0]
//   BRAM    : o_bram_addr0, o_bram_ce0, o_bram_we0, o_bram_d0, i_bram_q0
//   Result  : o_shape_valid, i_shape_ready, o_shape[15:0], o_color[3:0],
//             o_shape_id[2:0], o_shape_rot[1:0], o_err
interface tetromino_fetch_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 4
);
    logic              i_req_valid;
    logic              o_req_ready;
    logic [2:0]        i_req_id;
    logic [1:0]        i_req_rot;

    logic [AWIDTH-1:0] o_bram_addr0;
    logic              o_bram_ce0;
    logic              o_bram_we0;
    logic [DWIDTH-1:0] o_bram_d0;
    logic [DWIDTH-1:0] i_bram_q0;

    logic              o_shape_valid;
    logic              i_shape_ready;
    logic [15:0]       o_shape;
    logic [3:0]        o_color;
    logic [2:0]        o_shape_id;
    logic [1:0]        o_shape_rot;
    logic              o_err;

    modport master (
        input  i_req_valid, i_req_id, i_req_rot, i_bram_q0, i_shape_ready,
        output o_req_ready, o_bram_addr0, o_bram_ce0, o_bram_we0, o_bram_d0,
               o_shape_valid, o_shape, o_color, o_shape_id, o_shape_rot, o_err
    );

    modport slave (
        output i_req_valid, i_req_id, i_req_rot, i_bram_q0, i_shape_ready,
        input  o_req_ready, o_bram_addr0, o_bram_ce0, o_bram_we0, o_bram_d0,
               o_shape_valid, o_shape, o_color, o_shape_id, o_shape_rot, o_err
    );
endinterface

// File: rtl/tetromino_fetch.sv
// tetromino_fetch
//   Fetches one piece word (bitmap [15:0], colour [19:16]) from BRAM port 0,
//   rotates the 4x4 bitmap clockwise one quarter turn per cycle and presents
//   the result on a valid/ready output. Read-only client of the BRAM.
//   clk     : single clock, shared with the BRAM
//   reset_n : asynchronous active-low reset
//   bus     : request / BRAM port-0 / result signals (master side)
//
//   state   | meaning
//   IDLE    | ready for a request
//   READ    | ce0 high, BRAM reading the latched id
//   CAPTURE | BRAM data valid, latch bitmap and colour, load turn counter
//   ROTATE  | one clockwise quarter turn per cycle until counter hits 0
//   OUT     | result valid, held until the consumer accepts it
module tetromino_fetch #(
    parameter int DWIDTH     = 32,
    parameter int AWIDTH     = 4,
    parameter int MEM_DEPTH  = 10,
    parameter int NUM_PIECES = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    tetromino_fetch_if.master bus
);

    // Ids are 3 bits wide and must also land inside the BRAM.
    localparam int NUM_VALID_A = (NUM_PIECES < MEM_DEPTH) ? NUM_PIECES : MEM_DEPTH;
    localparam int NUM_VALID   = (NUM_VALID_A < 8) ? NUM_VALID_A : 8;
    localparam logic [3:0] ID_LIMIT = 4'(NUM_VALID);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        ROTATE  = 3'd3,
        OUT     = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        id_q, id_d;
    logic [1:0]        rot_q, rot_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [15:0]       shape_q, shape_d;
    logic [3:0]        color_q, color_d;
    logic              err_q, err_d;
    logic              ce0_q, ce0_d;
    logic [AWIDTH-1:0] addr0_q, addr0_d;

    // new[r][c] = old[3-c][r], bit index = row*4+col
    function automatic logic [15:0] rot_cw(input logic [15:0] s);
        logic [15:0] n;
        n = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                n[r*4+c] = s[(3-c)*4+r];
            end
        end
        return n;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            id_q    <= '0;
            rot_q   <= '0;
            cnt_q   <= '0;
            shape_q <= '0;
            color_q <= '0;
            err_q   <= 1'b0;
            ce0_q   <= 1'b0;
            addr0_q <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            rot_q   <= rot_d;
            cnt_q   <= cnt_d;
            shape_q <= shape_d;
            color_q <= color_d;
            err_q   <= err_d;
            ce0_q   <= ce0_d;
            addr0_q <= addr0_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        rot_d   = rot_q;
        cnt_d   = cnt_q;
        shape_d = shape_q;
        color_d = color_q;
        err_d   = err_q;
        ce0_d   = 1'b0;
        addr0_d = addr0_q;

        unique case (state_q)
            IDLE: begin
                if (bus.i_req_valid) begin
                    id_d  = bus.i_req_id;
                    rot_d = bus.i_req_rot;
                    if ({1'b0, bus.i_req_id} >= ID_LIMIT) begin
                        // Invalid id: answer straight away, never touch the BRAM.
                        shape_d = '0;
                        color_d = '0;
                        err_d   = 1'b1;
                        state_d = OUT;
                    end else begin
                        ce0_d   = 1'b1;
                        addr0_d = AWIDTH'(bus.i_req_id);
                        state_d = READ;
                    end
                end
            end
            READ: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                shape_d = bus.i_bram_q0[15:0];
                color_d = bus.i_bram_q0[19:16];
                err_d   = 1'b0;
                cnt_d   = rot_q;
                state_d = (rot_q == 2'd0) ? OUT : ROTATE;
            end
            ROTATE: begin
                shape_d = rot_cw(shape_q);
                cnt_d   = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (bus.i_shape_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.o_req_ready   = (state_q == IDLE);
    assign bus.o_shape_valid = (state_q == OUT);
    assign bus.o_shape       = shape_q;
    assign bus.o_color       = color_q;
    assign bus.o_shape_id    = id_q;
    assign bus.o_shape_rot   = rot_q;
    assign bus.o_err         = err_q;
    assign bus.o_bram_ce0    = ce0_q;
    assign bus.o_bram_addr0  = addr0_q;
    assign bus.o_bram_we0    = 1'b0;
    assign bus.o_bram_d0     = '0;

    // Upper word bits carry nothing for this block.
    generate
        if (DWIDTH > 20) begin : g_q0_hi
            logic unused_q0_hi;
            assign unused_q0_hi = ^bus.i_bram_q0[DWIDTH-1:20];
        end
    endgenerate

endmodule

// File: tb/tb_tetromino_fetch.sv
// tb_tetromino_fetch
//   Scoreboard bench for tetromino_fetch: the stimulus process pushes expected
//   results and expected ce0 addresses; a negedge monitor pops and compares
//   whenever a result is accepted or ce0 is seen.
module tb_tetromino_fetch;
    localparam int DWIDTH = 32;
    localparam int AWIDTH = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    tetromino_fetch_if #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) bus ();

    tetromino_fetch #(
        .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .MEM_DEPTH(10), .NUM_PIECES(7)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    logic [15:0] base_shape [0:6];
    logic [3:0]  base_color [0:6];
    logic [31:0] mem [0:9];

    always @(posedge clk) begin
        if (bus.o_bram_ce0)
            bus.i_bram_q0 <= (bus.o_bram_addr0 < 4'd10) ? mem[bus.o_bram_addr0] : 32'hDEAD_BEEF;
    end

    typedef struct {
        logic [15:0] shape;
        logic [3:0]  color;
        logic [2:0]  id;
        logic [1:0]  rot;
        logic        err;
        int          exp_edge;
    } exp_t;

    exp_t sb_q[$];
    int   ce_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   we0_seen = 1'b0;

    // Closed-form reference: k quarter turns clockwise.
    function automatic logic [15:0] ref_rot(input logic [15:0] s, input logic [1:0] k);
        logic [15:0] n;
        n = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                case (k)
                    2'd0: n[r*4+c] = s[r*4+c];
                    2'd1: n[r*4+c] = s[(3-c)*4+r];
                    2'd2: n[r*4+c] = s[(3-r)*4+(3-c)];
                    default: n[r*4+c] = s[c*4+(3-r)];
                endcase
            end
        end
        return n;
    endfunction

    // Monitor
    logic prev_valid = 1'b0;
    int   rise_edge  = -1;
    exp_t m_e;
    int   m_a;
    always @(negedge clk) begin
        if (bus.o_shape_valid && !prev_valid) rise_edge = cyc + 1;
        prev_valid = bus.o_shape_valid;
        if (bus.o_bram_we0 !== 1'b0) we0_seen = 1'b1;
        if (bus.o_bram_ce0) begin
            n_tests++;
            if (ce_q.size() == 0) begin
                n_fail++;
                $display("FAIL ce0_pulse: got ce0 at addr=%0d, required no ce0", bus.o_bram_addr0);
            end else begin
                m_a = ce_q.pop_front();
                if (int'(bus.o_bram_addr0) != m_a) begin
                    n_fail++;
                    $display("FAIL ce0_addr: got %0d, required %0d", bus.o_bram_addr0, m_a);
                end
            end
        end
        if (bus.o_shape_valid && bus.i_shape_ready) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL result_unexpected: got id=%0d shape=%h, required no result",
                         bus.o_shape_id, bus.o_shape);
            end else begin
                m_e = sb_q.pop_front();
                if (bus.o_shape !== m_e.shape || bus.o_color !== m_e.color ||
                    bus.o_shape_id !== m_e.id || bus.o_shape_rot !== m_e.rot ||
                    bus.o_err !== m_e.err || rise_edge != m_e.exp_edge) begin
                    n_fail++;
                    $display("FAIL result id%0d rot%0d: got shape=%h color=%h id=%0d rot=%0d err=%b valid_edge=%0d, required shape=%h color=%h id=%0d rot=%0d err=%b valid_edge=%0d",
                             m_e.id, m_e.rot, bus.o_shape, bus.o_color, bus.o_shape_id,
                             bus.o_shape_rot, bus.o_err, rise_edge, m_e.shape, m_e.color,
                             m_e.id, m_e.rot, m_e.err, m_e.exp_edge);
                end
            end
        end
    end

    // Caller must be #1 after a rising edge.
    task automatic do_req(input logic [2:0] id, input logic [1:0] rot,
                          input logic [15:0] shp, input logic [3:0] col, input logic err);
        bit   done;
        exp_t e;
        done = 1'b0;
        bus.i_req_valid = 1'b1;
        bus.i_req_id    = id;
        bus.i_req_rot   = rot;
        for (int t = 0; t < 200 && !done; t++) begin
            if (bus.o_req_ready) begin
                @(posedge clk); #1;
                e.shape    = shp;
                e.color    = col;
                e.id       = id;
                e.rot      = rot;
                e.err      = err;
                e.exp_edge = cyc + (err ? 1 : 3 + int'(rot));
                sb_q.push_back(e);
                if (!err) ce_q.push_back(int'(id));
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        bus.i_req_valid = 1'b0;
        bus.i_req_id    = 3'd5;
        bus.i_req_rot   = 2'd2;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_timeout id%0d: got no handshake, required handshake", id);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb_q.size() != 0 || ce_q.size() != 0) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d results pending, required 0", sb_q.size());
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_tests++;
        if (bus.o_req_ready !== 1'b1 || bus.o_shape_valid !== 1'b0 || bus.o_err !== 1'b0 ||
            bus.o_bram_ce0 !== 1'b0 || bus.o_bram_addr0 !== '0 || bus.o_shape !== '0 ||
            bus.o_color !== '0 || bus.o_shape_id !== '0 || bus.o_shape_rot !== '0) begin
            n_fail++;
            $display("FAIL %s: got rdy=%b vld=%b err=%b ce=%b addr=%0d shape=%h col=%h id=%0d rot=%0d, required rdy=1 rest 0",
                     name, bus.o_req_ready, bus.o_shape_valid, bus.o_err, bus.o_bram_ce0,
                     bus.o_bram_addr0, bus.o_shape, bus.o_color, bus.o_shape_id, bus.o_shape_rot);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        base_shape[0] = 16'h00F0; base_color[0] = 4'h3;
        base_shape[1] = 16'h0066; base_color[1] = 4'h5;
        base_shape[2] = 16'h0072; base_color[2] = 4'h7;
        base_shape[3] = 16'h0036; base_color[3] = 4'h2;
        base_shape[4] = 16'h0063; base_color[4] = 4'h1;
        base_shape[5] = 16'h0074; base_color[5] = 4'h6;
        base_shape[6] = 16'h0071; base_color[6] = 4'h4;
        mem[0] = 32'h0003_00F0;
        mem[1] = 32'h5A55_0066;
        mem[2] = 32'hA5A7_0072;
        mem[3] = 32'hFFF2_0036;
        mem[4] = 32'h0001_0063;
        mem[5] = 32'h1236_0074;
        mem[6] = 32'hC3C4_0071;
        mem[7] = 32'hFFFF_FFFF;
        mem[8] = 32'h1234_5678;
        mem[9] = 32'h8765_4321;

        bus.i_req_valid   = 1'b0;
        bus.i_req_id      = 3'd0;
        bus.i_req_rot     = 2'd0;
        bus.i_shape_ready = 1'b0;

        #1;
        check_reset_outputs("reset_state");
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // Base word, rotations 0..3
        bus.i_shape_ready = 1'b1;
        do_req(3'd0, 2'd0, 16'h00F0, 4'h3, 1'b0); drain();
        do_req(3'd0, 2'd1, 16'h4444, 4'h3, 1'b0); drain();
        do_req(3'd0, 2'd2, 16'h0F00, 4'h3, 1'b0); drain();
        do_req(3'd0, 2'd3, 16'h2222, 4'h3, 1'b0); drain();

        // Invalid id
        do_req(3'd7, 2'd1, 16'h0000, 4'h0, 1'b1); drain();

        // Backpressure with a competing request
        bus.i_shape_ready = 1'b0;
        do_req(3'd0, 2'd1, 16'h4444, 4'h3, 1'b0);
        t = 0;
        while (!bus.o_shape_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        bus.i_req_valid = 1'b1;
        bus.i_req_id    = 3'd3;
        bus.i_req_rot   = 2'd0;
        for (int i = 0; i < 20; i++) begin
            n_tests++;
            if (bus.o_shape_valid !== 1'b1 || bus.o_req_ready !== 1'b0 ||
                bus.o_shape !== 16'h4444 || bus.o_color !== 4'h3 ||
                bus.o_shape_id !== 3'd0 || bus.o_shape_rot !== 2'd1 || bus.o_err !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got vld=%b rdy=%b shape=%h col=%h id=%0d rot=%0d err=%b, required vld=1 rdy=0 shape=4444 col=3 id=0 rot=1 err=0",
                         i, bus.o_shape_valid, bus.o_req_ready, bus.o_shape, bus.o_color,
                         bus.o_shape_id, bus.o_shape_rot, bus.o_err);
            end
            @(posedge clk); #1;
        end
        bus.i_req_valid   = 1'b0;
        bus.i_shape_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (bus.o_req_ready !== 1'b1 || bus.o_shape_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: got rdy=%b vld=%b, required rdy=1 vld=0",
                     bus.o_req_ready, bus.o_shape_valid);
        end
        drain();

        // Reset during ROTATE
        do_req(3'd2, 2'd3, ref_rot(16'h0072, 2'd3), 4'h7, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        sb_q.delete();
        ce_q.delete();
        #1;
        check_reset_outputs("reset_mid_rotate");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        do_req(3'd2, 2'd0, 16'h0072, 4'h7, 1'b0); drain();

        // Back-to-back, all pieces
        for (int i = 0; i < 7; i++) begin
            do_req(3'(i), 2'(i % 4), ref_rot(base_shape[i], 2'(i % 4)), base_color[i], 1'b0);
        end
        drain();

        n_tests++;
        if (we0_seen) begin
            n_fail++;
            $display("FAIL we0: got we0 asserted, required never");
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tetromino_fetch.md
# tetromino_fetch

Read-side client of the tetromino BRAM's port 0 (`addr0`/`ce0`/`we0`/`q0`/`d0`), owned by the game logic core.
- On request it fetches the base 4x4 bitmap and colour of one piece from BRAM.
- It rotates the bitmap clockwise the requested number of quarter turns, one turn per cycle.
- It presents the result on a valid/ready output for collision and render logic downstream.
- The AXI4-lite side writes piece words into BRAM port 1; this block only reads.

## Interface
Parameters:
- `DWIDTH`, 32, BRAM data width; must be ≥ 20.
- `AWIDTH`, 4, BRAM address width.
- `MEM_DEPTH`, 10, BRAM depth in words.
- `NUM_PIECES`, 7, number of valid piece ids. Must be ≤ `MEM_DEPTH`.

Ports:
- `clk`  in  1  single clock, shared with the BRAM.
- `reset_n`  in  1  asynchronous active-low reset.
- `i_req_valid`  in  1  fetch request.
- `o_req_ready`  out  1  request accepted when `i_req_valid` and `o_req_ready` are both high at a rising edge.
- `i_req_id`  in  3  piece id, used as the BRAM word address.
- `i_req_rot`  in  2  number of clockwise quarter turns.
- `o_bram_addr0`  out  AWIDTH  BRAM port-0 address.
- `o_bram_ce0`  out  1  BRAM port-0 chip enable.
- `o_bram_we0`  out  1  BRAM port-0 write enable; constant 0.
- `o_bram_d0`  out  DWIDTH  BRAM port-0 write data; constant 0.
- `i_bram_q0`  in  DWIDTH  BRAM port-0 read data; valid 1 cycle after `ce0`.
- `o_shape_valid`  out  1  result valid.
- `i_shape_ready`  in  1  consumer accepts the result.
- `o_shape`  out  16  4x4 bitmap. Bit index = row*4+col; row 0 is the top row, col 0 is the left column.
- `o_color`  out  4  piece colour.
- `o_shape_id`  out  3  echo of the request id.
- `o_shape_rot`  out  2  echo of the request rotation.
- `o_err`  out  1  request had an invalid id; qualified by `o_shape_valid`.

## Operation
- BRAM word layout: bits [15:0] hold the base bitmap (rotation 0), bits [19:16] hold the colour, and the remaining bits are ignored.
- States: IDLE, READ, CAPTURE, ROTATE, OUT.
- IDLE:
  - `o_req_ready` = 1; it is high only in IDLE.
  - On handshake, latch id and rot into registers.
  - If id ≥ `NUM_PIECES`: go to OUT with shape = 0, color = 0, err = 1. No BRAM access occurs.
  - Otherwise go to READ.
- READ: `o_bram_ce0` = 1 and `o_bram_addr0` = latched id, both registered outputs. Next state is CAPTURE.
- CAPTURE:
  - Latch shape = q0[15:0] and color = q0[19:16]; set err = 0.
  - Load the turn counter with rot.
  - Go to OUT if rot == 0, else go to ROTATE.
- ROTATE, one clockwise turn per cycle:
  - new[r][c] = old[3-c][r].
  - The counter decrements each turn; the block leaves ROTATE for OUT after the turn that brings the counter to 0.
- OUT:
  - `o_shape_valid` = 1, and all result outputs are held stable.
  - When `i_shape_ready` = 1, go to IDLE. `o_shape_valid` drops in the next cycle.
- A new request is never accepted while a result is pending.
- `i_req_*` are sampled only at handshake; changes at other times are ignored.

## Timing
- Reset, asynchronous and active-low:
  - State goes to IDLE.
  - `o_req_ready` = 1.
  - `o_shape_valid`, `o_err`, `o_bram_ce0` = 0.
  - `o_bram_addr0`, `o_shape`, `o_color`, `o_shape_id`, `o_shape_rot` = 0.
- Reset mid-operation discards the in-flight request and any pending result. No `ce0` is issued after reset asserts.
- Latency, counted from handshake edge N:
  - READ occupies cycle N+1.
  - CAPTURE occupies cycle N+2.
  - For a valid id, `o_shape_valid` rises at edge N+3+rot.
  - For an invalid id, `o_shape_valid` rises at edge N+1.
- `ce0` is asserted for exactly one cycle per valid request. `we0` never asserts.
- If `i_shape_ready` is already high when valid rises, the result is consumed in one cycle, and `o_req_ready` returns on the following edge.
- Maximum throughput is one request per 4+rot cycles.
- Output backpressure has no upper bound; outputs must remain stable throughout.

## Test plan
- BRAM[0] = 0x0003_00F0, request id 0, rot 0 → shape 0x00F0, color 3, err 0. Valid is at N+3 and `ce0` pulses once with addr 0.
- Same word, rot 1/2/3 → shape 0x4444 / 0x0F00 / 0x2222. Valid is at N+4 / N+5 / N+6, and rot echo is correct.
- Request id 7 (≥ `NUM_PIECES`) → valid at N+1, err 1, shape 0, color 0, and no `ce0`.
- Hold `i_shape_ready` = 0 for 20 cycles in OUT → outputs stable, `o_req_ready` = 0, and a concurrent `i_req_valid` is not accepted. Releasing ready → IDLE on the next edge.
- Assert `reset_n` low during ROTATE (id 2, rot 3) → all outputs at reset values immediately. After release, request id 2, rot 0 → correct base shape.
- Back-to-back requests with `i_shape_ready` tied high, ids 0..6 with rot = id mod 4 → every result matches a reference rotation model, in order with no drops.
